// File: rtl/sensor_seq_pkg.sv
// Shared types and constants for the sensor poll sequencer: FSM state encoding,
// UART header nibble and the channel-index width helper.
package sensor_seq_pkg;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      SPI_REQ  = 3'd1,
      SPI_WAIT = 3'd2,
      TX_HDR   = 3'd3,
      TX_DATA  = 3'd4,
      TX_WAIT  = 3'd5,
      NEXT     = 3'd6
   } state_t;

   localparam logic [3:0] HDR_NIBBLE = 4'hA;

   // Channel index width; a single channel still needs one bit.
   function automatic int cw_of(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/poll_tick_gen.sv
// Sweep-rate tick generator: counts 0..PERIOD_CYC-1 while enabled and flags the
// last count for one cycle; the count is held at 0 while disabled.
module poll_tick_gen #(
   parameter int CLK_FREQ_HZ = 10_000_000,
   parameter int POLL_HZ     = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic enable,
   output logic tick
);

   localparam int PERIOD_CYC = CLK_FREQ_HZ / POLL_HZ;
   localparam int CNT_W      = (PERIOD_CYC > 1) ? $clog2(PERIOD_CYC) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(PERIOD_CYC - 1);

   logic [CNT_W-1:0] r_cnt;
   logic             w_last;

   assign w_last = (r_cnt == LAST);
   assign tick   = enable && w_last;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_cnt <= '0;
      end else if (!enable || w_last) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/sensor_poll_sequencer.sv
// Periodic SPI sensor sweep with UART forwarding of each good sample.
// Define SENSOR_SEQ_HEADER_EN to prefix every sample byte with {4'hA, ch}.
module sensor_poll_sequencer
   import sensor_seq_pkg::*;
#(
   parameter int CLK_FREQ_HZ = 10_000_000,
   parameter int POLL_HZ     = 1,
   parameter int N_CH        = 4,
   parameter int DATA_W      = 8,
   parameter int TIMEOUT_CYC = 1024,
   localparam int CW         = cw_of(N_CH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              enable,
   input  logic [N_CH-1:0]   ch_mask,
   input  logic              clr_flags,
   output logic              spi_start,
   output logic [CW-1:0]     spi_ch,
   input  logic              spi_done,
   input  logic [DATA_W-1:0] spi_data,
   output logic              uart_send,
   output logic [7:0]        uart_data,
   input  logic              uart_ready,
   input  logic [CW-1:0]     rd_ch,
   output logic [DATA_W-1:0] rd_value,
   output logic              sweep_done,
   output logic              overrun,
   output logic [N_CH-1:0]   err_ch
);

   localparam int XW = (DATA_W > 8) ? DATA_W : 8;
   localparam int TW = $clog2(TIMEOUT_CYC + 1);

   state_t            r_state;
   state_t            w_state_nxt;
   logic [N_CH-1:0]   r_mask;
   logic [CW-1:0]     r_ch;
   logic [TW-1:0]     r_tmo;
   logic [DATA_W-1:0] r_value [N_CH];
   logic [DATA_W-1:0] r_rd_value;
   logic              r_overrun;
   logic [N_CH-1:0]   r_err_ch;
   logic              r_after_hdr;
   logic              r_wait_seen;

   logic              w_tick;
   logic [CW:0]       w_first;
   logic [CW:0]       w_next;
   logic              w_tmo_hit;
   logic [XW-1:0]     w_ext;
   logic [N_CH-1:0]   w_err_set;
   logic              w_ovr_set;

   // Lowest set bit of m at or above 'from', returned as {found, index}.
   function automatic logic [CW:0] find_bit(input logic [N_CH-1:0] m, input int from);
      logic [CW:0] res;
      res = '0;
      for (int i = N_CH - 1; i >= 0; i--) begin
         if (m[i] && (i >= from)) res = {1'b1, CW'(i)};
      end
      return res;
   endfunction

   poll_tick_gen #(
      .CLK_FREQ_HZ (CLK_FREQ_HZ),
      .POLL_HZ     (POLL_HZ)
   ) u_tick (
      .clk    (clk),
      .rst    (rst),
      .enable (enable),
      .tick   (w_tick)
   );

   assign w_first   = find_bit(ch_mask, 0);
   assign w_next    = find_bit(r_mask, int'(r_ch) + 1);
   assign w_tmo_hit = (r_tmo == TW'(TIMEOUT_CYC - 1));
   assign w_ext     = XW'(r_value[r_ch]);
   assign w_ovr_set = w_tick && (r_state != IDLE);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= IDLE;
      else      r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         IDLE:     if (w_tick && w_first[CW]) w_state_nxt = SPI_REQ;
         SPI_REQ:  w_state_nxt = SPI_WAIT;
         SPI_WAIT: begin
            if (spi_done) begin
`ifdef SENSOR_SEQ_HEADER_EN
               w_state_nxt = TX_HDR;
`else
               w_state_nxt = TX_DATA;
`endif
            end else if (w_tmo_hit) begin
               w_state_nxt = NEXT;
            end
         end
         TX_HDR, TX_DATA: if (uart_ready) w_state_nxt = TX_WAIT;
         // The cycle right after a send pulse never counts as ready.
         TX_WAIT:  if (r_wait_seen && uart_ready) w_state_nxt = r_after_hdr ? TX_DATA : NEXT;
         NEXT:     w_state_nxt = w_next[CW] ? SPI_REQ : IDLE;
         default:  w_state_nxt = IDLE;
      endcase
   end

   always_comb begin
      spi_start  = 1'b0;
      uart_send  = 1'b0;
      uart_data  = '0;
      sweep_done = 1'b0;
      case (r_state)
         SPI_REQ: spi_start = 1'b1;
         TX_HDR: begin
            uart_send = uart_ready;
            uart_data = {HDR_NIBBLE, 4'(r_ch)};
         end
         TX_DATA: begin
            uart_send = uart_ready;
            uart_data = w_ext[7:0];
         end
         NEXT:    sweep_done = !w_next[CW];
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_mask      <= '0;
         r_ch        <= '0;
         r_tmo       <= '0;
         r_after_hdr <= 1'b0;
         r_wait_seen <= 1'b0;
      end else begin
         r_wait_seen <= (r_state == TX_WAIT);
         case (r_state)
            IDLE: if (w_tick) begin
               r_mask <= ch_mask;
               r_ch   <= w_first[CW-1:0];
            end
            SPI_REQ:  r_tmo <= '0;
            SPI_WAIT: r_tmo <= r_tmo + TW'(1);
            TX_HDR:   if (uart_ready) r_after_hdr <= 1'b1;
            TX_DATA:  if (uart_ready) r_after_hdr <= 1'b0;
            NEXT:     if (w_next[CW]) r_ch <= w_next[CW-1:0];
            default: ;
         endcase
      end
   end

   always_comb begin
      w_err_set = '0;
      if ((r_state == SPI_WAIT) && !spi_done && w_tmo_hit) w_err_set[r_ch] = 1'b1;
   end

   // Sticky flags: a set in the same cycle as clr_flags wins.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_overrun <= 1'b0;
         r_err_ch  <= '0;
      end else begin
         r_overrun <= w_ovr_set || (r_overrun && !clr_flags);
         r_err_ch  <= w_err_set | (r_err_ch & {N_CH{!clr_flags}});
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < N_CH; i++) r_value[i] <= '0;
         r_rd_value <= '0;
      end else begin
         if ((r_state == SPI_WAIT) && spi_done) r_value[r_ch] <= spi_data;
         r_rd_value <= (32'(rd_ch) < 32'(N_CH)) ? r_value[rd_ch] : '0;
      end
   end

   assign spi_ch   = r_ch;
   assign rd_value = r_rd_value;
   assign overrun  = r_overrun;
   assign err_ch   = r_err_ch;

endmodule

// File: doc/sensor_poll_sequencer.md
SENSOR_POLL_SEQUENCER -- requirements
Module: sensor_poll_sequencer

Interface
REQ-001 SHALL have parameter CLK_FREQ_HZ, default 10_000_000, meaning input clock frequency.
REQ-002 SHALL have parameter POLL_HZ, default 1, meaning sweep rate; PERIOD_CYC = CLK_FREQ_HZ/POLL_HZ.
REQ-003 SHALL have parameter N_CH, default 4, meaning number of sensor channels (1..16).
REQ-004 SHALL have parameter DATA_W, default 8, meaning sample width.
REQ-005 SHALL have parameter TIMEOUT_CYC, default 1024, meaning maximum SPI wait per channel.
REQ-006 SHALL have port clk, input, 1 bit, meaning the single system clock; all logic on its rising edge.
REQ-007 SHALL have port rst, input, 1 bit, meaning asynchronous active-low reset.
REQ-008 SHALL have ports enable (in, 1), ch_mask (in, N_CH) and clr_flags (in, 1), meaning run, channel select and sticky-flag clear.
REQ-009 SHALL have ports spi_start (out, 1), spi_ch (out, CW=$clog2(N_CH), min 1), spi_done (in, 1) and spi_data (in, DATA_W), meaning the SPI read handshake.
REQ-010 SHALL have ports uart_send (out, 1), uart_data (out, 8) and uart_ready (in, 1), meaning the UART byte handshake.
REQ-011 SHALL have ports rd_ch (in, CW) and rd_value (out, DATA_W), meaning the display readback of the last good sample.
REQ-012 SHALL have ports sweep_done (out, 1), overrun (out, 1) and err_ch (out, N_CH), meaning sweep-end pulse, sticky missed tick and sticky per-channel timeout.

Function
REQ-013 SHALL count 0..PERIOD_CYC-1 while enable=1 and assert a 1-cycle tick at PERIOD_CYC-1; the counter SHALL be held at 0 while enable=0.
REQ-014 SHALL use FSM states IDLE, SPI_REQ, SPI_WAIT, TX_HDR, TX_DATA, TX_WAIT, NEXT.
REQ-015 On a tick in IDLE, SHALL latch ch_mask and go to SPI_REQ for the lowest set bit; a latched mask of 0 SHALL return to IDLE with no activity and no sweep_done.
REQ-016 In SPI_REQ, SHALL drive spi_ch and pulse spi_start for exactly 1 cycle; spi_ch SHALL stay stable until leaving SPI_WAIT.
REQ-017 In SPI_WAIT, SHALL capture spi_data into value[ch] on the first cycle spi_done=1; spi_done outside SPI_WAIT SHALL be ignored.
REQ-018 When TIMEOUT_CYC cycles elapse in SPI_WAIT without spi_done, SHALL set err_ch[ch], leave value[ch] unchanged, send no UART bytes and go to NEXT.
REQ-019 SHALL pulse uart_send for 1 cycle only when uart_ready=1, with uart_data valid in that cycle.
REQ-020 In TX_WAIT, SHALL ignore uart_ready in the cycle after the pulse, then wait for uart_ready=1 before the next byte or state.
REQ-021 NEXT SHALL advance to the next higher set bit of the latched mask; after the highest set bit it SHALL pulse sweep_done for 1 cycle and return to IDLE.
REQ-022 A tick arriving in any state other than IDLE SHALL be dropped and SHALL set overrun.
REQ-023 clr_flags=1 SHALL clear overrun and err_ch on the next edge; a simultaneous set SHALL win.
REQ-024 rd_value SHALL be registered, equal to value[rd_ch] with 1-cycle latency; rd_ch >= N_CH SHALL read 0.
REQ-025 enable falling mid-sweep SHALL let the current sweep complete.

Reset
REQ-026 rst=0 SHALL immediately force IDLE, tick counter 0, all value[] 0, rd_value 0, and spi_start, uart_send, sweep_done, overrun and err_ch 0, with spi_ch and uart_data 0.
REQ-027 Reset mid-sweep SHALL abort without a further spi_start or uart_send pulse after release, until the next tick.

Configuration
REQ-028 With SENSOR_SEQ_HEADER_EN defined, SHALL send per good sample a header byte {4'hA, ch[3:0]} (TX_HDR) followed by the sample byte.
REQ-029 Without SENSOR_SEQ_HEADER_EN, TX_HDR SHALL be unreachable and only the sample byte is sent.
REQ-030 For DATA_W>8 the sample byte SHALL be spi_data[7:0]; for DATA_W<8 it SHALL be zero-extended.

Structure
REQ-031 Package sensor_seq_pkg SHALL hold the FSM state enum, HDR_NIBBLE=4'hA and a clog2-based CW helper.
REQ-032 Tick generation SHALL be a sub-module poll_tick_gen (params CLK_FREQ_HZ, POLL_HZ; ports clk, rst, enable, tick).

Verification (CLK_FREQ_HZ=100, POLL_HZ=10, N_CH=4, DATA_W=8, TIMEOUT_CYC=16)
REQ-033 Mask 4'b0101, SPI model returns 8'h3C for ch0 and 8'h7E for ch2 -> spi_ch 0 then 2, UART bytes 3C,7E (header on: A0,3C,A2,7E), one sweep_done, rd_ch=2 gives 7E after 1 cycle.
REQ-034 Mask 4'b0010, SPI model silent -> spi_start once, err_ch=4'b0010 after 16 cycles, no uart_send, sweep_done, value[1] unchanged.
REQ-035 uart_ready held 0 for 30 cycles so a tick lands mid-sweep -> overrun=1, no second sweep started, sweep completes; clr_flags pulse -> overrun=0.
REQ-036 Mask 4'b0000 -> ticks every 10 cycles, no spi_start, no sweep_done.
REQ-037 rst=0 asserted during SPI_WAIT -> all outputs 0 immediately; after release, first spi_start occurs only after the next tick (cycle 10).
